// File: rtl/teeter_game_ctrl.sv
// -----------------------------------------------------------------------------
// teeter_game_ctrl
// Game sequencer for the teeter ball. Loads the level start point into the ball
// physics block, gates physics, runs the pre-play countdown and the per-attempt
// time limit, detects hole and goal hits once per frame, and tracks lives and
// level progression.
//
// Optional feature macro: TEETER_PAUSE_EN
//   defined   -> pause_btn toggles a freeze of PLAY (reported as o_state = PLAY)
//   undefined -> pause_btn is accepted but ignored; no pause logic is built
// -----------------------------------------------------------------------------
module teeter_game_ctrl #(
    parameter int SPRITE_SIZE      = 32,
    parameter int HIT_R            = 12,
    parameter int LEVELS           = 4,
    parameter int LIVES            = 3,
    parameter int FPS              = 60,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int TIME_LIMIT_S     = 60,
    parameter int HOLD_FRAMES      = 90
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       screenend,
    input  logic       start_btn,
    input  logic [9:0] bl_x,
    input  logic [9:0] bl_y,
    input  logic [9:0] i_start_x,
    input  logic [9:0] i_start_y,
    input  logic [9:0] i_hole_x,
    input  logic [9:0] i_hole_y,
    input  logic [9:0] i_goal_x,
    input  logic [9:0] i_goal_y,
    input  logic       pause_btn,
    output logic       is_game_playing,
    output logic       ball_rst,
    output logic [9:0] o_init_x,
    output logic [9:0] o_init_y,
    output logic [2:0] o_state,
    output logic [3:0] o_level,
    output logic [2:0] o_lives,
    output logic [7:0] o_time_left
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    // One frame counter serves both the countdown and the FALL/DONE hold.
    localparam int FRAME_MAX = (COUNTDOWN_FRAMES > HOLD_FRAMES) ? COUNTDOWN_FRAMES : HOLD_FRAMES;
    localparam int FCNT_W    = $clog2(FRAME_MAX + 1);
    localparam int SEC_W     = $clog2(FPS + 1);

    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] COUNT_INIT = FCNT_W'(COUNTDOWN_FRAMES);
    localparam logic [FCNT_W-1:0] HOLD_INIT  = FCNT_W'(HOLD_FRAMES);
    localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(FPS - 1);
    localparam logic [SEC_W-1:0]  SEC_ONE    = SEC_W'(1);
    localparam logic [7:0]        TIME_INIT  = 8'(TIME_LIMIT_S);
    localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]        LAST_LEVEL = 4'(LEVELS - 1);

    // Hit arithmetic is done 12 bits wide so centre offsets never wrap.
    localparam logic [11:0] HALF_SPRITE = 12'(SPRITE_SIZE / 2);
    localparam logic [11:0] HIT_WIN     = 12'(HIT_R);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_PLAY  = 3'd3,
        ST_FALL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_WIN   = 3'd6,
        ST_OVER  = 3'd7
    } state_t;

    state_t              state_reg,     state_next;
    logic [3:0]          level_reg,     level_next;
    logic [2:0]          lives_reg,     lives_next;
    logic [7:0]          timer_reg,     timer_next;
    logic [FCNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [SEC_W-1:0]    sec_cnt_reg,   sec_cnt_next;
    logic [9:0]          init_x_reg,    init_x_next;
    logic [9:0]          init_y_reg,    init_y_next;
    logic                playing_reg,   playing_next;
    logic                ball_rst_reg,  ball_rst_next;

    // Pause freeze as seen by the sequencer (constant 0 without the feature).
    logic                frozen;
    logic                frozen_next;

    // ------------------------------------------------------------------
    // Hit detection: four axis probes (hole x/y, goal x/y). A target is hit
    // when both of its axis probes report the ball centre inside the window.
    // ------------------------------------------------------------------
    logic [9:0] probe_pos [4];
    logic [9:0] probe_ctr [4];
    logic [3:0] probe_near;
    logic       hole_hit;
    logic       goal_hit;

    assign probe_pos[0] = bl_x;
    assign probe_pos[1] = bl_y;
    assign probe_pos[2] = bl_x;
    assign probe_pos[3] = bl_y;
    assign probe_ctr[0] = i_hole_x;
    assign probe_ctr[1] = i_hole_y;
    assign probe_ctr[2] = i_goal_x;
    assign probe_ctr[3] = i_goal_y;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_probe
            logic [11:0] delta;
            logic [11:0] mag;
            // Signed distance from ball centre to target centre, then |delta|.
            assign delta = {2'b00, probe_pos[gi]} + HALF_SPRITE - {2'b00, probe_ctr[gi]};
            assign mag   = delta[11] ? (12'd0 - delta) : delta;
            assign probe_near[gi] = (mag < HIT_WIN);
        end
    endgenerate

    assign hole_hit = probe_near[0] & probe_near[1];
    assign goal_hit = probe_near[2] & probe_near[3];

    // ------------------------------------------------------------------
    // Optional pause
    // ------------------------------------------------------------------
`ifdef TEETER_PAUSE_EN
    logic paused_reg;
    logic paused_next;

    // Pause flag register; cleared by reset so a new game never starts frozen.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            paused_reg <= 1'b0;
        end else begin
            paused_reg <= paused_next;
        end
    end

    // Toggle only while PLAY persists; a same-cycle PLAY exit takes priority.
    always_comb begin
        paused_next = paused_reg & (state_reg == ST_PLAY);
        if (state_reg == ST_PLAY && state_next == ST_PLAY && pause_btn) begin
            paused_next = ~paused_reg;
        end
    end

    assign frozen      = paused_reg;
    assign frozen_next = paused_next;
`else
    logic unused_pause_btn;

    assign unused_pause_btn = pause_btn;
    assign frozen           = 1'b0;
    assign frozen_next      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // Holds the sequencer state; reset drops straight back to IDLE.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Game counters and the latched start position.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            level_reg     <= 4'd0;
            lives_reg     <= LIVES_INIT;
            timer_reg     <= TIME_INIT;
            frame_cnt_reg <= '0;
            sec_cnt_reg   <= '0;
            init_x_reg    <= 10'd0;
            init_y_reg    <= 10'd0;
        end else begin
            level_reg     <= level_next;
            lives_reg     <= lives_next;
            timer_reg     <= timer_next;
            frame_cnt_reg <= frame_cnt_next;
            sec_cnt_reg   <= sec_cnt_next;
            init_x_reg    <= init_x_next;
            init_y_reg    <= init_y_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and counter updates
    // ------------------------------------------------------------------
    // All frame-driven work happens only on screenend; start wins in IDLE/WIN/OVER.
    always_comb begin
        state_next     = state_reg;
        level_next     = level_reg;
        lives_next     = lives_reg;
        timer_next     = timer_reg;
        frame_cnt_next = frame_cnt_reg;
        sec_cnt_next   = sec_cnt_reg;
        init_x_next    = init_x_reg;
        init_y_next    = init_y_reg;

        case (state_reg)
            ST_IDLE, ST_WIN, ST_OVER: begin
                if (start_btn) begin
                    state_next = ST_LOAD;
                    level_next = 4'd0;
                    lives_next = LIVES_INIT;
                end
            end

            ST_LOAD: begin
                // The level ROM is addressed by level_reg, already settled here.
                init_x_next    = i_start_x;
                init_y_next    = i_start_y;
                timer_next     = TIME_INIT;
                frame_cnt_next = COUNT_INIT;
                state_next     = ST_COUNT;
            end

            ST_COUNT: begin
                if (screenend) begin
                    if (frame_cnt_reg == FCNT_ONE) begin
                        state_next   = ST_PLAY;
                        sec_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg - FCNT_ONE;
                    end
                end
            end

            ST_PLAY: begin
                if (screenend && !frozen) begin
                    if (goal_hit) begin
                        state_next     = ST_DONE;
                        frame_cnt_next = HOLD_INIT;
                    end else if (hole_hit) begin
                        state_next     = ST_FALL;
                        frame_cnt_next = HOLD_INIT;
                    end else if (sec_cnt_reg == SEC_LAST) begin
                        sec_cnt_next = '0;
                        timer_next   = timer_reg - 8'd1;
                        if (timer_reg == 8'd1) begin
                            state_next     = ST_FALL;
                            frame_cnt_next = HOLD_INIT;
                        end
                    end else begin
                        sec_cnt_next = sec_cnt_reg + SEC_ONE;
                    end
                end
            end

            ST_FALL: begin
                if (screenend) begin
                    if (frame_cnt_reg == FCNT_ONE) begin
                        if (lives_reg == 3'd1) begin
                            state_next = ST_OVER;
                            lives_next = 3'd0;
                        end else begin
                            state_next = ST_LOAD;
                            lives_next = lives_reg - 3'd1;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg - FCNT_ONE;
                    end
                end
            end

            ST_DONE: begin
                if (screenend) begin
                    if (frame_cnt_reg == FCNT_ONE) begin
                        if (level_reg == LAST_LEVEL) begin
                            state_next = ST_WIN;
                        end else begin
                            state_next = ST_LOAD;
                            level_next = level_reg + 4'd1;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt_reg - FCNT_ONE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, decoded from the next state and registered
    // ------------------------------------------------------------------
    // Physics runs only in an unfrozen PLAY; ball is held in reset outside PLAY.
    always_comb begin
        playing_next  = (state_next == ST_PLAY) && !frozen_next;
        ball_rst_next = (state_next != ST_PLAY);
    end

    // Output registers so control lines line up with o_state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            playing_reg  <= 1'b0;
            ball_rst_reg <= 1'b1;
        end else begin
            playing_reg  <= playing_next;
            ball_rst_reg <= ball_rst_next;
        end
    end

    assign is_game_playing = playing_reg;
    assign ball_rst        = ball_rst_reg;
    assign o_init_x        = init_x_reg;
    assign o_init_y        = init_y_reg;
    assign o_state         = state_reg;
    assign o_level         = level_reg;
    assign o_lives         = lives_reg;
    assign o_time_left     = timer_reg;

endmodule

// File: tb/tb_teeter_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_teeter_game_ctrl
// Self-checking bench for teeter_game_ctrl: a hit-window vector table, directed
// multi-cycle sequences (level walk, lives/time-out, reset, pause) and a
// randomized run, all compared every cycle against a game-rule model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_teeter_game_ctrl;

    localparam int SPRITE = 32;
    localparam int HIT_R  = 12;
    localparam int LEVELS = 4;
    localparam int LIVES  = 3;
    localparam int FPS    = 60;
    localparam int CD     = 180;
    localparam int TL     = 60;
    localparam int HOLD   = 90;

    localparam int S_IDLE = 0, S_LOAD = 1, S_COUNT = 2, S_PLAY = 3;
    localparam int S_FALL = 4, S_DONE = 5, S_WIN = 6, S_OVER = 7;

    localparam int FAR_X = 20;
    localparam int FAR_Y = 20;

    logic       CLK       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       screenend = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic [9:0] bl_x      = 10'd0;
    logic [9:0] bl_y      = 10'd0;
    logic [9:0] i_start_x, i_start_y, i_hole_x, i_hole_y, i_goal_x, i_goal_y;
    logic       is_game_playing, ball_rst;
    logic [9:0] o_init_x, o_init_y;
    logic [2:0] o_state;
    logic [3:0] o_level;
    logic [2:0] o_lives;
    logic [7:0] o_time_left;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    overlap  = 1'b0;
    string phase    = "init";

    // Level ROM seen by the DUT (addressed by its own o_level)
    assign i_start_x = 10'(100 + 20 * int'(o_level));
    assign i_start_y = 10'd120;
    assign i_hole_x  = 10'(300 + 10 * int'(o_level));
    assign i_hole_y  = 10'd200;
    assign i_goal_x  = overlap ? 10'(308 + 10 * int'(o_level)) : 10'd500;
    assign i_goal_y  = overlap ? 10'd205 : 10'(300 + 10 * int'(o_level));

    // Same ROM for the model, addressed by the model's level
    function automatic int rom_start_x(int l); return 100 + 20 * l; endfunction
    function automatic int rom_hole_x(int l);  return 300 + 10 * l; endfunction
    function automatic int rom_hole_y(int l);  return 200; endfunction
    function automatic int rom_goal_x(int l);  return overlap ? 308 + 10 * l : 500; endfunction
    function automatic int rom_goal_y(int l);  return overlap ? 205 : 300 + 10 * l; endfunction

    teeter_game_ctrl dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .screenend      (screenend),
        .start_btn      (start_btn),
        .bl_x           (bl_x),
        .bl_y           (bl_y),
        .i_start_x      (i_start_x),
        .i_start_y      (i_start_y),
        .i_hole_x       (i_hole_x),
        .i_hole_y       (i_hole_y),
        .i_goal_x       (i_goal_x),
        .i_goal_y       (i_goal_y),
        .pause_btn      (pause_btn),
        .is_game_playing(is_game_playing),
        .ball_rst       (ball_rst),
        .o_init_x       (o_init_x),
        .o_init_y       (o_init_y),
        .o_state        (o_state),
        .o_level        (o_level),
        .o_lives        (o_lives),
        .o_time_left    (o_time_left)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Game-rule model: counts elapsed frames and derives seconds by division
    // ------------------------------------------------------------------
    int m_st, m_level, m_lives, m_ix, m_iy, m_tl, m_cd, m_pf, m_hold;
    bit m_paused;

    task automatic model_reset();
        m_st = S_IDLE; m_level = 0; m_lives = LIVES; m_ix = 0; m_iy = 0;
        m_tl = TL; m_cd = 0; m_pf = 0; m_hold = 0; m_paused = 1'b0;
    endtask

    function automatic bit near(int b, int c);
        int d;
        d = b + SPRITE / 2 - c;
        if (d < 0) d = -d;
        return d < HIT_R;
    endfunction

    task automatic model_step();
        bit was_paused;
        bit g, h;
        case (m_st)
            S_IDLE, S_WIN, S_OVER: begin
                if (start_btn) begin
                    m_st = S_LOAD; m_level = 0; m_lives = LIVES;
                end
            end
            S_LOAD: begin
                m_ix = rom_start_x(m_level); m_iy = 120; m_tl = TL; m_cd = 0; m_st = S_COUNT;
            end
            S_COUNT: begin
                if (screenend) begin
                    m_cd++;
                    if (m_cd == CD) begin
                        m_st = S_PLAY; m_pf = 0;
                    end
                end
            end
            S_PLAY: begin
                was_paused = m_paused;
                if (!was_paused && screenend) begin
                    g = near(int'(bl_x), rom_goal_x(m_level)) && near(int'(bl_y), rom_goal_y(m_level));
                    h = near(int'(bl_x), rom_hole_x(m_level)) && near(int'(bl_y), rom_hole_y(m_level));
                    if (g) begin
                        m_st = S_DONE; m_hold = 0;
                    end else if (h) begin
                        m_st = S_FALL; m_hold = 0;
                    end else begin
                        m_pf++;
                        m_tl = TL - m_pf / FPS;
                        if (m_tl == 0) begin
                            m_st = S_FALL; m_hold = 0;
                        end
                    end
                end
`ifdef TEETER_PAUSE_EN
                if (pause_btn && m_st == S_PLAY) m_paused = !was_paused;
`endif
                if (m_st != S_PLAY) m_paused = 1'b0;
            end
            S_FALL: begin
                if (screenend) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        if (m_lives == 1) begin
                            m_st = S_OVER; m_lives = 0;
                        end else begin
                            m_lives--; m_st = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                if (screenend) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        if (m_level == LEVELS - 1) begin
                            m_st = S_WIN;
                        end else begin
                            m_level++; m_st = S_LOAD;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    // ------------------------------------------------------------------
    // Checkers
    // ------------------------------------------------------------------
    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        bit exp_play, exp_brst, bad;
        exp_play = (m_st == S_PLAY) && !m_paused;
        exp_brst = (m_st != S_PLAY);
        bad = (int'(o_state) != m_st) || (int'(o_level) != m_level) ||
              (int'(o_lives) != m_lives) || (int'(o_time_left) != m_tl) ||
              (int'(o_init_x) != m_ix) || (int'(o_init_y) != m_iy) ||
              (is_game_playing != exp_play) || (ball_rst != exp_brst);
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL model[%s] t=%0t: got st=%0d lvl=%0d lives=%0d tl=%0d init=(%0d,%0d) play=%0b brst=%0b; expected st=%0d lvl=%0d lives=%0d tl=%0d init=(%0d,%0d) play=%0b brst=%0b",
                     phase, $time, o_state, o_level, o_lives, o_time_left, o_init_x, o_init_y,
                     is_game_playing, ball_rst, m_st, m_level, m_lives, m_tl, m_ix, m_iy,
                     exp_play, exp_brst);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input bit se, input bit sb, input bit pb, input int bx, input int by);
        screenend = se; start_btn = sb; pause_btn = pb;
        bl_x = 10'(bx); bl_y = 10'(by);
        @(posedge CLK);
        model_step();
        #1;
        check_model();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, FAR_X, FAR_Y);
    endtask

    task automatic load_to_play();
        cyc(1'b0, 1'b0, 1'b0, FAR_X, FAR_Y);
        frames(CD);
    endtask

    task automatic new_game_to_play();
        cyc(1'b0, 1'b1, 1'b0, FAR_X, FAR_Y);
        load_to_play();
    endtask

    task automatic hard_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_state", int'(o_state), S_IDLE);
        check_val("rst_playing", int'(is_game_playing), 0);
        check_val("rst_ball_rst", int'(ball_rst), 1);
        check_model();
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int target;   // 0 = hole, 1 = goal
        int offx;
        int offy;
        bit ovl;      // goal placed overlapping the hole
        int exp_st;
    } hit_vec_t;

    hit_vec_t vecs [10];

    initial begin
        int bx, by, mode, off;

        vecs[0] = '{0,  11,   0, 1'b0, S_FALL};
        vecs[1] = '{0,  12,   0, 1'b0, S_PLAY};
        vecs[2] = '{0, -11,   0, 1'b0, S_FALL};
        vecs[3] = '{0, -12,   0, 1'b0, S_PLAY};
        vecs[4] = '{0,   0,  11, 1'b0, S_FALL};
        vecs[5] = '{0,   0, -12, 1'b0, S_PLAY};
        vecs[6] = '{1,   0,   0, 1'b0, S_DONE};
        vecs[7] = '{1,  11, -11, 1'b0, S_DONE};
        vecs[8] = '{1,  12,   0, 1'b0, S_PLAY};
        vecs[9] = '{0,   4,   2, 1'b1, S_DONE};

        // ---------------- reset and first start ----------------
        phase = "reset";
        model_reset();
        #22;
        check_val("reset_lives", int'(o_lives), LIVES);
        check_val("reset_time", int'(o_time_left), TL);
        check_val("reset_init_x", int'(o_init_x), 0);
        check_val("reset_level", int'(o_level), 0);
        check_model();
        @(negedge CLK);
        rst_n = 1'b1;

        phase = "start";
        frames(3);
        check_val("idle_hold", int'(o_state), S_IDLE);
        cyc(1'b0, 1'b1, 1'b0, FAR_X, FAR_Y);
        check_val("start_to_load", int'(o_state), S_LOAD);
        cyc(1'b0, 1'b0, 1'b0, FAR_X, FAR_Y);
        check_val("load_to_count", int'(o_state), S_COUNT);
        check_val("load_init_x", int'(o_init_x), 100);
        check_val("load_init_y", int'(o_init_y), 120);
        cyc(1'b0, 1'b1, 1'b0, FAR_X, FAR_Y);
        check_val("start_ignored_count", int'(o_state), S_COUNT);
        frames(CD - 1);
        check_val("count_179", int'(o_state), S_COUNT);
        frames(1);
        check_val("count_180_play", int'(o_state), S_PLAY);
        check_val("play_gates_physics", int'(is_game_playing), 1);
        check_val("play_ball_rst", int'(ball_rst), 0);

        // ---------------- hit-window table ----------------
        for (int v = 0; v < 10; v++) begin
            phase = $sformatf("hitvec%0d", v);
            hard_reset();
            overlap = vecs[v].ovl;
            new_game_to_play();
            if (vecs[v].target == 0) begin
                bx = rom_hole_x(m_level) - SPRITE / 2 + vecs[v].offx;
                by = rom_hole_y(m_level) - SPRITE / 2 + vecs[v].offy;
            end else begin
                bx = rom_goal_x(m_level) - SPRITE / 2 + vecs[v].offx;
                by = rom_goal_y(m_level) - SPRITE / 2 + vecs[v].offy;
            end
            cyc(1'b1, 1'b0, 1'b0, bx, by);
            check_val($sformatf("hit_state_v%0d", v), int'(o_state), vecs[v].exp_st);
            if (vecs[v].exp_st == S_FALL) begin
                frames(HOLD);
                check_val($sformatf("fall_lives_v%0d", v), int'(o_lives), LIVES - 1);
                check_val($sformatf("fall_reload_v%0d", v), int'(o_state), S_LOAD);
            end else if (vecs[v].exp_st == S_DONE) begin
                frames(HOLD);
                check_val($sformatf("done_level_v%0d", v), int'(o_level), 1);
                check_val($sformatf("done_reload_v%0d", v), int'(o_state), S_LOAD);
            end
            overlap = 1'b0;
        end

        // ---------------- level walk to WIN ----------------
        phase = "levels";
        hard_reset();
        cyc(1'b0, 1'b1, 1'b0, FAR_X, FAR_Y);
        for (int l = 0; l < LEVELS; l++) begin
            load_to_play();
            cyc(1'b1, 1'b0, 1'b0, rom_goal_x(l) - SPRITE / 2, rom_goal_y(l) - SPRITE / 2);
            check_val($sformatf("goal_done_l%0d", l), int'(o_state), S_DONE);
            frames(HOLD - 1);
            check_val($sformatf("hold_done_l%0d", l), int'(o_state), S_DONE);
            frames(1);
            if (l < LEVELS - 1) begin
                check_val($sformatf("next_level_l%0d", l), int'(o_level), l + 1);
                check_val($sformatf("next_load_l%0d", l), int'(o_state), S_LOAD);
            end
        end
        check_val("win_state", int'(o_state), S_WIN);
        frames(5);
        check_val("win_frozen", int'(o_state), S_WIN);
        check_val("win_level", int'(o_level), LEVELS - 1);
        cyc(1'b1, 1'b1, 1'b0, FAR_X, FAR_Y);
        check_val("win_restart", int'(o_state), S_LOAD);
        check_val("win_restart_level", int'(o_level), 0);

        // ---------------- lives and time-out ----------------
        phase = "lives";
        for (int k = 0; k < 2; k++) begin
            load_to_play();
            cyc(1'b1, 1'b0, 1'b0, rom_hole_x(0) - SPRITE / 2, rom_hole_y(0) - SPRITE / 2);
            frames(HOLD);
            check_val($sformatf("lives_after_fall%0d", k), int'(o_lives), LIVES - 1 - k);
        end
        load_to_play();
        frames(FPS);
        check_val("time_first_second", int'(o_time_left), TL - 1);
        frames(TL * FPS - FPS - 1);
        check_val("time_last_second", int'(o_time_left), 1);
        check_val("time_still_play", int'(o_state), S_PLAY);
        frames(1);
        check_val("time_zero", int'(o_time_left), 0);
        check_val("timeout_fall", int'(o_state), S_FALL);
        frames(HOLD);
        check_val("over_state", int'(o_state), S_OVER);
        check_val("over_lives", int'(o_lives), 0);
        cyc(1'b0, 1'b1, 1'b0, FAR_X, FAR_Y);
        check_val("over_restart", int'(o_state), S_LOAD);
        check_val("over_restart_lives", int'(o_lives), LIVES);
        cyc(1'b0, 1'b0, 1'b0, FAR_X, FAR_Y);
        check_val("reload_time", int'(o_time_left), TL);

        // ---------------- reset during PLAY ----------------
        phase = "midreset";
        frames(CD);
        frames(10);
        hard_reset();

        // ---------------- pause ----------------
        phase = "pause";
        new_game_to_play();
        frames(30);
`ifdef TEETER_PAUSE_EN
        cyc(1'b0, 1'b0, 1'b1, FAR_X, FAR_Y);
        check_val("pause_state", int'(o_state), S_PLAY);
        check_val("pause_playing", int'(is_game_playing), 0);
        check_val("pause_ball_rst", int'(ball_rst), 0);
        frames(200);
        check_val("pause_time_kept", int'(o_time_left), TL);
        cyc(1'b0, 1'b0, 1'b1, FAR_X, FAR_Y);
        check_val("resume_playing", int'(is_game_playing), 1);
        frames(30);
        check_val("resume_time", int'(o_time_left), TL - 1);
        cyc(1'b1, 1'b0, 1'b1, rom_goal_x(0) - SPRITE / 2, rom_goal_y(0) - SPRITE / 2);
        check_val("pause_vs_goal", int'(o_state), S_DONE);
`else
        cyc(1'b0, 1'b0, 1'b1, FAR_X, FAR_Y);
        check_val("pause_ignored", int'(is_game_playing), 1);
        frames(30);
        check_val("pause_ignored_time", int'(o_time_left), TL - 1);
`endif

        // ---------------- randomized run ----------------
        phase = "random";
        hard_reset();
        bx = FAR_X;
        by = FAR_Y;
        for (int i = 0; i < 20000; i++) begin
            if (i % 40 == 0) begin
                mode = int'($urandom_range(0, 9));
                off  = int'($urandom_range(0, 28)) - 14;
                if (mode == 0) begin
                    bx = rom_hole_x(m_level) - SPRITE / 2 + off;
                    by = rom_hole_y(m_level) - SPRITE / 2 + int'($urandom_range(0, 28)) - 14;
                end else if (mode == 1) begin
                    bx = rom_goal_x(m_level) - SPRITE / 2 + off;
                    by = rom_goal_y(m_level) - SPRITE / 2 + int'($urandom_range(0, 28)) - 14;
                end else begin
                    bx = int'($urandom_range(0, 200));
                    by = int'($urandom_range(0, 100));
                end
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 99) == 0), bx, by);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
